// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and digit helpers for the four-digit multiplexed hex display.
package hex_scan_driver_pkg;

   localparam int unsigned DIGITS  = 4;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned DATA_W  = DIGITS * DIGIT_W;
   localparam int unsigned IDX_W   = 2;

   // All digit enables inactive (active-low)
   localparam logic [DIGITS-1:0] DIG_OFF = 4'b1111;

   // Active-low one-hot enable for digit idx
   function automatic logic [DIGITS-1:0] dig_sel(input logic [IDX_W-1:0] idx);
      return ~(DIGITS'(1) << idx);
   endfunction

   // Extract hex digit idx from a packed value
   function automatic logic [DIGIT_W-1:0] digit_of(input logic [DATA_W-1:0] v,
                                                   input logic [IDX_W-1:0]  idx);
      return v[idx*DIGIT_W +: DIGIT_W];
   endfunction

   // Leading-zero test: digit idx (never digit 0) is dark when it and every digit above are zero
   function automatic logic lz_blank(input logic [DATA_W-1:0] v,
                                     input logic [IDX_W-1:0]  idx);
      logic zero;
      zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (i >= int'(idx)) begin
            zero = zero & (v[i*DIGIT_W +: DIGIT_W] == '0);
         end
      end
      return (idx != '0) && zero;
   endfunction

endpackage

// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan driver for a four-digit hex display with
// frame-synchronous update, leading-zero suppression and blink.
module hex_scan_driver
   import hex_scan_driver_pkg::*;
#(
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLINK_FRAMES = 125
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WE,
   input  logic [DATA_W-1:0] WDATA,
   input  logic              LZ_EN,
   input  logic              BLINK,
   output logic [DIGIT_W-1:0] NIBBLE,
   output logic [DIGITS-1:0] DIG_N,
   output logic              PEND,
   output logic [DATA_W-1:0] DISP_VAL
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]     presc;
   logic [IDX_W-1:0]  idx;
   logic [BW-1:0]     blink_cnt;
   logic              phase;
   logic [DATA_W-1:0] pending;

   logic              tick;
   logic              frame;
   logic [PW-1:0]     presc_next;
   logic [IDX_W-1:0]  idx_next;
   logic [BW-1:0]     blink_cnt_next;
   logic              phase_next;
   logic [DATA_W-1:0] shadow_next;
   logic              blank;

   // Next-state for slot timing, frame sync, blink phase and digit blanking
   always_comb begin
      tick           = 1'b0;
      frame          = 1'b0;
      presc_next     = presc;
      idx_next       = idx;
      blink_cnt_next = blink_cnt;
      phase_next     = phase;
      shadow_next    = DISP_VAL;
      blank          = 1'b0;

      tick  = (presc == PW'(PRESCALE - 1));
      frame = tick && (idx == IDX_W'(DIGITS - 1));

      presc_next = tick ? '0 : PW'(presc + PW'(1));
      if (tick) begin
         idx_next = IDX_W'(idx + IDX_W'(1));
      end

      if (frame) begin
         if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase;
         end else begin
            blink_cnt_next = BW'(blink_cnt + BW'(1));
         end
         if (PEND) begin
            shadow_next = pending;
         end
      end

      // Blink first, then leading-zero suppression; either darkens the digit
      blank = (BLINK && phase_next) || (LZ_EN && lz_blank(shadow_next, idx_next));
   end

   // State and registered outputs; display outputs move only on slot ticks
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         presc     <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         pending   <= '0;
         PEND      <= 1'b0;
         DISP_VAL  <= '0;
         NIBBLE    <= '0;
         DIG_N     <= dig_sel('0);
      end else begin
         presc     <= presc_next;
         idx       <= idx_next;
         blink_cnt <= blink_cnt_next;
         phase     <= phase_next;
         DISP_VAL  <= shadow_next;

         // A new write always wins over the frame-boundary clear
         if (WE) begin
            pending <= WDATA;
            PEND    <= 1'b1;
         end else if (frame) begin
            PEND    <= 1'b0;
         end

         if (tick) begin
            NIBBLE <= digit_of(shadow_next, idx_next);
            DIG_N  <= blank ? DIG_OFF : dig_sel(idx_next);
         end
      end
   end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: clock cycles per digit slot (1 kHz slot rate at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLINK_FRAMES, default 125: scan frames per blink half-period.
REQ-003 SHALL have port CLK  in  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port WE  in  1  write strobe; WDATA is sampled on every CLK edge where WE=1.
REQ-006 SHALL have port WDATA  in  16  four hex digits; digit i = WDATA[4i+3:4i], digit 0 rightmost.
REQ-007 SHALL have port LZ_EN  in  1  leading-zero suppression enable.
REQ-008 SHALL have port BLINK  in  1  blink enable.
REQ-009 SHALL have port NIBBLE  out  4  current digit value, fed to the SevenSeg decoder IN.
REQ-010 SHALL have port DIG_N  out  4  active-low digit enables, one-hot-low or all-high.
REQ-011 SHALL have port PEND  out  1  a write is held and not yet displayed.
REQ-012 SHALL have port DISP_VAL  out  16  value currently being displayed (shadow register).

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick = prescaler at PRESCALE-1.
REQ-014 Digit index SHALL advance by one on each tick and wrap from 3 to 0.
REQ-015 Frame boundary = tick while index is 3.
REQ-016 WE=1 SHALL load WDATA into the pending register and set PEND=1; back-to-back writes: last write wins.
REQ-017 At a frame boundary with PEND=1, the shadow register SHALL load the pending register and PEND SHALL clear.
REQ-018 WE=1 on the frame-boundary cycle SHALL take priority: the shadow register loads the old pending value, the pending register loads the new WDATA, and PEND stays 1 (no write lost).
REQ-019 The shadow register SHALL change only at frame boundaries (no torn frames).
REQ-020 NIBBLE SHALL equal shadow digit[index]; NIBBLE and DIG_N SHALL be registered and SHALL update on the same cycle as the index.
REQ-021 DIG_N SHALL drive bit[index] low and all other bits high unless the digit is blanked, in which case DIG_N = 4'b1111.
REQ-022 With LZ_EN=1, digit i (i = 1..3) SHALL be blanked when shadow digits 3..i are all zero; digit 0 is never blanked by suppression.
REQ-023 The blink counter SHALL count frame boundaries 0..BLINK_FRAMES-1 and toggle the blink phase on wrap.
REQ-024 With BLINK=1 and phase=1, all digits SHALL be blanked; BLINK=0 SHALL override immediately regardless of phase.
REQ-025 Blink SHALL be evaluated before LZ_EN; either condition blanks the digit.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 RESET=1 SHALL asynchronously force prescaler=0, index=0, blink counter=0, phase=0, shadow=0, pending=0, PEND=0.
REQ-028 During and after reset: NIBBLE=4'h0, DIG_N=4'b1110, DISP_VAL=16'h0000.
REQ-029 Reset mid-frame SHALL discard any pending write; the first tick after release SHALL occur PRESCALE cycles after reset deassertion.

Structure
REQ-030 A shared package SHALL hold the digit count (4), the digit width (4), and the all-off DIG_N constant 4'b1111.
REQ-031 The block SHALL be a single module with no sub-modules; the SevenSeg decoder is instantiated by the parent, not inside this block.

Verification (PRESCALE=4, BLINK_FRAMES=2)
REQ-032 Reset release, no writes -> DIG_N cycles 1110,1101,1011,0111 with 4 cycles per slot; NIBBLE=0 throughout.
REQ-033 WE with WDATA=16'h1234 mid-frame -> PEND=1 immediately; DISP_VAL=16'h1234 and PEND=0 after the next frame boundary; slots then show NIBBLE 4,3,2,1.
REQ-034 WE with 16'hAAAA on the frame-boundary cycle, pending=16'h5555 -> DISP_VAL=16'h5555, PEND stays 1; 16'hAAAA is displayed one frame later.
REQ-035 LZ_EN=1, value 16'h0070 -> digits 3 and 2 show DIG_N=1111; digit 1 shows 7; digit 0 shows 0. Value 16'h0000 -> only digit 0 is lit.
REQ-036 BLINK=1 -> all digits dark for frames 2-3, lit for frames 0-1 and 4-5; dropping BLINK during a dark frame relights on the next slot update.
REQ-037 RESET asserted mid-slot with PEND=1 -> outputs return immediately to their reset values; PEND=0; the held write is never displayed.
